// File: rtl/single_port_blockram_requester.sv
// Initiator front end for a single-port block RAM: read/write arbitration with a 2-entry read response FIFO.
// Optional CLEAR_ON_RESET_EN: zero every RAM set after reset release before accepting requests.
module single_port_blockram_requester #(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
    parameter int NUMBER_SETS                 = 64,
    parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
    input  logic                                   clk_in,
    input  logic                                   reset_n_in,
    input  logic                                   read_req_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       read_req_addr_in,
    output logic                                   read_req_ready_out,
    input  logic                                   write_req_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_req_addr_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_req_data_in,
    output logic                                   write_req_ready_out,
    output logic                                   read_resp_valid_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_resp_data_out,
    input  logic                                   read_resp_ready_in,
    output logic                                   ram_access_en_out,
    output logic                                   ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_access_set_addr_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in,
    output logic                                   busy_out
);

    localparam int DW = SINGLE_ELEMENT_SIZE_IN_BITS;
    localparam int AW = SET_PTR_WIDTH_IN_BITS;
    localparam logic PRIO_READ  = 1'b0;
    localparam logic PRIO_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state_q;
    logic            prio_q;
    logic            inflight_q;
    logic [1:0]      occ_q;
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [DW-1:0]   buf_q [2];
    logic            busy_q;
`ifdef CLEAR_ON_RESET_EN
    localparam logic [AW-1:0] LAST_SET = AW'(NUMBER_SETS - 1);
    logic [AW-1:0]   clear_ptr_q;
`endif

    logic            run;
    logic            pop;
    logic [2:0]      credit;
    logic            rd_ok;
    logic            rd_fire;
    logic            wr_fire;

    // Valid/ready: a request transfers in a cycle where valid & ready are both high;
    // readies look at the opposite valid so at most one side is granted per cycle.
    always_comb begin
        run                 = (state_q == ST_RUN);
        read_resp_valid_out = (occ_q != 2'd0);
        read_resp_data_out  = buf_q[rd_ptr_q];
        pop                 = read_resp_valid_out & read_resp_ready_in;
        // Outstanding reads after this cycle's pop; a new read needs a free buffer slot.
        credit              = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_ok               = (credit < 3'd2);
        read_req_ready_out  = run & rd_ok & (!write_req_valid_in | (prio_q == PRIO_READ));
        write_req_ready_out = run & (!read_req_valid_in | !rd_ok | (prio_q == PRIO_WRITE));
        rd_fire             = read_req_valid_in & read_req_ready_out;
        wr_fire             = write_req_valid_in & write_req_ready_out;
        busy_out            = busy_q;
    end

    always_comb begin
        ram_access_en_out       = 1'b0;
        ram_write_en_out        = 1'b0;
        ram_access_set_addr_out = '0;
        ram_write_element_out   = '0;
`ifdef CLEAR_ON_RESET_EN
        if (state_q == ST_CLEAR) begin
            ram_access_en_out       = 1'b1;
            ram_write_en_out        = 1'b1;
            ram_access_set_addr_out = clear_ptr_q;
        end else
`endif
        if (rd_fire) begin
            ram_access_en_out       = 1'b1;
            ram_access_set_addr_out = read_req_addr_in;
        end else if (wr_fire) begin
            ram_access_en_out       = 1'b1;
            ram_write_en_out        = 1'b1;
            ram_access_set_addr_out = write_req_addr_in;
            ram_write_element_out   = write_req_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= ST_START;
            prio_q     <= PRIO_READ;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            busy_q     <= 1'b0;
`ifdef CLEAR_ON_RESET_EN
            clear_ptr_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_START: begin
`ifdef CLEAR_ON_RESET_EN
                    state_q     <= ST_CLEAR;
                    busy_q      <= 1'b1;
                    clear_ptr_q <= '0;
`else
                    state_q     <= ST_RUN;
`endif
                end
                ST_CLEAR: begin
`ifdef CLEAR_ON_RESET_EN
                    if (clear_ptr_q == LAST_SET) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        clear_ptr_q <= clear_ptr_q + 1'b1;
                    end
`else
                    state_q <= ST_RUN;
`endif
                end
                ST_RUN: begin
                    // Contention with room for a read: whichever side was granted yields next time.
                    if (read_req_valid_in && write_req_valid_in && rd_ok) begin
                        prio_q <= ~prio_q;
                    end
                end
                default: state_q <= ST_START;
            endcase

            inflight_q <= rd_fire;
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= ram_read_element_in;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

endmodule
